// File: rtl/muldiv_pkg.sv
// muldiv_pkg: op encodings and FSM states shared by the mul/div unit.
// Imported by muldiv_if and muldiv_unit.
package muldiv_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } state_t;

endpackage

// File: rtl/muldiv_if.sv
// muldiv_if: start/done bundle between control and the mul/div unit.
// The abort signal exists only when MULDIV_ABORT_EN is defined.
interface muldiv_if #(
  parameter int WIDTH = 32
);
  import muldiv_pkg::*;

  logic             start;
  op_t              op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

`ifdef MULDIV_ABORT_EN
  logic abort;

  modport master (
    output start, op, a, b, abort,
    input  busy, done, div_zero, hi, lo
  );

  modport slave (
    input  start, op, a, b, abort,
    output busy, done, div_zero, hi, lo
  );
`else
  modport master (
    output start, op, a, b,
    input  busy, done, div_zero, hi, lo
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, div_zero, hi, lo
  );
`endif

endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative signed/unsigned multiply/divide, fixed latency.
// Define MULDIV_ABORT_EN to add an abort input that flushes CALC/FIX.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic      clk,
  input logic      reset,
  muldiv_if.slave  bus
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int AW = 2 * WIDTH + 1;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [AW-1:0]    acc;
  logic [WIDTH-1:0] opd;
  logic             is_div;
  logic             neg_lo;
  logic             neg_hi;
  logic             dz;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  assign bus.busy     = busy;
  assign bus.done     = done;
  assign bus.div_zero = div_zero;
  assign bus.hi       = hi;
  assign bus.lo       = lo;

  logic             sgn;
  logic             dv;
  logic             sa;
  logic             sb;
  logic             bz;
  logic [WIDTH-1:0] ma;
  logic [WIDTH-1:0] mb;

  always_comb begin
    sgn = 1'b0;
    dv  = 1'b0;
    unique case (bus.op)
      OP_MULT:  sgn = 1'b1;
      OP_MULTU: sgn = 1'b0;
      OP_DIV: begin
        sgn = 1'b1;
        dv  = 1'b1;
      end
      OP_DIVU:  dv = 1'b1;
    endcase
  end

  // magnitude of MIN is 2^(WIDTH-1), exact as an unsigned WIDTH value
  assign sa = sgn & bus.a[WIDTH-1];
  assign sb = sgn & bus.b[WIDTH-1];
  assign ma = sa ? -bus.a : bus.a;
  assign mb = sb ? -bus.b : bus.b;
  assign bz = (bus.b == '0);

  logic [WIDTH:0]  sum;
  logic [WIDTH:0]  trial;
  logic [AW-1:0]   shl;
  logic [AW-1:0]   nxt;

  always_comb begin
    sum   = acc[AW-1:WIDTH]
          + (acc[0] ? {1'b0, opd} : '0);
    shl   = {acc[AW-2:0], 1'b0};
    trial = shl[AW-1:WIDTH] - {1'b0, opd};
    nxt   = shl;
    if (!is_div)
      nxt = {1'b0, sum, acc[WIDTH-1:1]};
    else if (!trial[WIDTH])
      nxt = {trial, shl[WIDTH-1:1], 1'b1};
  end

  logic kill;
  logic take;

`ifdef MULDIV_ABORT_EN
  assign kill = bus.abort
              & ((state == CALC) | (state == FIX));
  assign take = bus.start & ~bus.abort;
`else
  assign kill = 1'b0;
  assign take = bus.start;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      acc      <= '0;
      opd      <= '0;
      is_div   <= 1'b0;
      neg_lo   <= 1'b0;
      neg_hi   <= 1'b0;
      dz       <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else if (kill) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: if (take) begin
          is_div <= dv;
          neg_lo <= sa ^ sb;
          neg_hi <= dv ? sa : (sa ^ sb);
          dz     <= dv & bz;
          acc    <= {{(WIDTH+1){1'b0}}, dv ? ma : mb};
          opd    <= dv ? mb : ma;
          cnt    <= CW'(WIDTH);
          busy   <= 1'b1;
          state  <= CALC;
        end
        CALC: begin
          acc <= nxt;
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1))
            state <= FIX;
        end
        FIX: begin
          if (is_div) begin
            lo <= dz ? '1
                : neg_lo ? -acc[WIDTH-1:0]
                : acc[WIDTH-1:0];
            hi <= neg_hi ? -acc[AW-2:WIDTH]
                : acc[AW-2:WIDTH];
          end else begin
            {hi, lo} <= neg_lo ? -acc[AW-2:0]
                      : acc[AW-2:0];
          end
          div_zero <= dz;
          done     <= 1'b1;
          state    <= DONE;
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed vectors with hand-computed results, WIDTH=32.
// Abort vectors run only when MULDIV_ABORT_EN is defined.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  muldiv_if #(.WIDTH(32)) bus();

  muldiv_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input op_t op,
                       input logic [31:0] a,
                       input logic [31:0] b);
    step();
    chk("idle_busy", bus.busy, 0);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    step();
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int n0, input int b0,
                           output int n, output int bc);
    n  = n0;
    bc = b0;
    while (n < 100) begin
      if (bus.busy) bc++;
      if (bus.done) break;
      step();
      n++;
    end
  endtask

  task automatic count_done(input int cyc, output int d);
    d = 0;
    for (int i = 0; i < cyc; i++) begin
      step();
      if (bus.done) d++;
    end
  endtask

  task automatic run_op(input string tag, input op_t op,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        input logic [31:0] eh,
                        input logic [31:0] el,
                        input logic ez);
    int n;
    int bc;
    issue(op, a, b);
    wait_done(1, 0, n, bc);
    chk({tag, "_lat"}, n, 34);
    chk({tag, "_busy"}, bc, 34);
    chk({tag, "_hi"}, bus.hi, eh);
    chk({tag, "_lo"}, bus.lo, el);
    chk({tag, "_dz"}, bus.div_zero, ez);
  endtask

  initial begin
    int n;
    int bc;
    int d;
    bus.start = 1'b0;
    bus.op    = OP_MULT;
    bus.a     = '0;
    bus.b     = '0;
`ifdef MULDIV_ABORT_EN
    bus.abort = 1'b0;
`endif
    reset = 1'b1;
    step();
    step();
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_dz", bus.div_zero, 0);
    chk("rst_hilo", {bus.hi, bus.lo}, 0);
    reset = 1'b0;

    run_op("mult_neg", OP_MULT, 32'hFFFFFFFD, 32'h7,
           32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0);
    run_op("multu", OP_MULTU, 32'hFFFFFFFF, 32'h2,
           32'h00000001, 32'hFFFFFFFE, 1'b0);
    run_op("mult_m1", OP_MULT, 32'hFFFFFFFF, 32'h2,
           32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0);
    run_op("mult_min", OP_MULT, 32'h80000000, 32'h80000000,
           32'h40000000, 32'h00000000, 1'b0);
    run_op("div_neg", OP_DIV, 32'hFFFFFFF9, 32'h2,
           32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
    run_op("divu", OP_DIVU, 32'h7, 32'h2,
           32'h1, 32'h3, 1'b0);
    run_op("divu_z", OP_DIVU, 32'h5, 32'h0,
           32'h5, 32'hFFFFFFFF, 1'b1);
    run_op("div_z", OP_DIV, 32'hFFFFFFF9, 32'h0,
           32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1);
    run_op("div_ovf", OP_DIV, 32'h80000000, 32'hFFFFFFFF,
           32'h0, 32'h80000000, 1'b0);
    run_op("div_mix", OP_DIV, 32'd100, 32'hFFFFFFF9,
           32'h2, 32'hFFFFFFF2, 1'b0);

    run_op("pre", OP_MULTU, 32'd3, 32'd5,
           32'h0, 32'd15, 1'b0);
    issue(OP_DIVU, 32'd100, 32'd7);
    n  = 1;
    bc = 0;
    while (n < 5) begin
      if (bus.busy) bc++;
      step();
      n++;
    end
    chk("calc_hold", {bus.hi, bus.lo}, 64'd15);
    bus.start = 1'b1;
    bus.op    = OP_MULT;
    bus.a     = 32'hFFFFFFFF;
    bus.b     = 32'hFFFFFFFF;
    if (bus.busy) bc++;
    step();
    n++;
    bus.start = 1'b0;
    wait_done(n, bc, n, bc);
    chk("busy_lat", n, 34);
    chk("busy_cyc", bc, 34);
    chk("busy_hi", bus.hi, 32'd2);
    chk("busy_lo", bus.lo, 32'd14);
    count_done(40, d);
    chk("busy_extra", d, 0);

`ifdef MULDIV_ABORT_EN
    run_op("ab_pre", OP_MULT, 32'd6, 32'd7,
           32'h0, 32'd42, 1'b0);
    issue(OP_DIV, 32'd1000, 32'hFFFFFFFD);
    repeat (9) step();
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    chk("ab_busy", bus.busy, 0);
    count_done(40, d);
    chk("ab_done", d, 0);
    chk("ab_hilo", {bus.hi, bus.lo}, 64'd42);
    run_op("ab_post", OP_DIVU, 32'd9, 32'd4,
           32'd1, 32'd2, 1'b0);
`endif

    run_op("rs_pre", OP_DIVU, 32'd5, 32'd0,
           32'd5, 32'hFFFFFFFF, 1'b1);
    issue(OP_DIVU, 32'd100, 32'd7);
    repeat (9) step();
    reset = 1'b1;
    step();
    chk("rs_busy", bus.busy, 0);
    chk("rs_hilo", {bus.hi, bus.lo}, 0);
    chk("rs_dz", bus.div_zero, 0);
    reset = 1'b0;
    count_done(40, d);
    chk("rs_done", d, 0);
    run_op("rs_post", OP_MULTU, 32'h10000, 32'h10000,
           32'h1, 32'h0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
